nonce_arbiter: RTL and testbench
================================

# nonce_arbiter

Round-robin arbiter that shares the single nonce result path (nonce bus plus nonce FIFO write port) between `NCORE` hashing cores inside the controller. Each core drops a found nonce into a private one-deep holding slot. The arbiter drains at most one slot per cycle into the FIFO, respecting FIFO back-pressure. A flush input discards stale results when a new job is loaded.

## Interface
Parameters:
- `NCORE`, default 2: number of hashing cores, 1..16.
- `NONCE_W`, default 64: nonce width in bits.

Ports:
- `clk`, in, 1: single clock, the 100 MHz hash clock.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `found`, in, `NCORE`: one-cycle pulse per core. The core has a result.
- `found_nonce`, in, `NCORE*NONCE_W`: nonce from core i on bits `[i*NONCE_W +: NONCE_W]`. Valid when `found[i]` is high.
- `flush`, in, 1: discard all pending slots. Pulsed on job load.
- `fifo_full`, in, 1: nonce FIFO full.
- `nonce_bus`, out, `NONCE_W`: registered nonce toward the FIFO.
- `nonce_bus_wr`, out, 1: FIFO write strobe, one cycle per nonce.
- `pending`, out, 1: OR of all slot-valid bits.
- `drop_cnt`, out, 16: saturating count of dropped nonces. Present only with `NONCE_ARB_DROP_CNT_EN`.

## Operation
Per-core state:
- `slot_v[i]`: slot-valid bit.
- `slot_d[i]`: `NONCE_W` data register.

Shared state:
- `ptr`: round-robin pointer, `$clog2(NCORE)` bits, or 1 bit when `NCORE` = 1.

Capture:
- When `found[i]` is high and the slot is empty, or is being granted this cycle: `slot_d[i]` takes `found_nonce[i]` and `slot_v[i]` sets.
- When `found[i]` is high and the slot is full and not granted this cycle: the new nonce is dropped. The old nonce is kept and `drop_cnt` is incremented.

Grant:
- Grant is combinational from `slot_v`, `ptr` and `fifo_full`.
- If `fifo_full` is low, select the first valid slot, searching i = `ptr`, `ptr`+1, … modulo `NCORE`.
- On a grant to core g, at the clock edge:
  - `nonce_bus` takes `slot_d[g]`.
  - `nonce_bus_wr` goes to 1.
  - `slot_v[g]` clears, unless a new `found[g]` arrives on the same edge.
  - `ptr` takes (g+1) mod `NCORE`.
- With no grant: `nonce_bus_wr` goes to 0, and `nonce_bus` and `ptr` hold.

Flush:
- `flush` high clears all `slot_v` and suppresses the grant in that cycle.
- A `found` arriving in the same cycle as `flush` is also discarded; flush wins.
- `ptr` and `drop_cnt` are not affected.

Back-pressure:
- `fifo_full` high means no grant. Slots hold indefinitely.
- The FIFO's own full is trusted. The arbiter never writes while `fifo_full` is sampled high.

Reset (`rst` low), asynchronous:
- `slot_v` = 0, `ptr` = 0.
- `nonce_bus` = 0, `nonce_bus_wr` = 0, `pending` = 0, `drop_cnt` = 0.
- `slot_d` is not reset.

## Timing
- Latency from a `found[i]` pulse in cycle N (empty slot, FIFO not full, no competition) to `nonce_bus_wr` high is cycle N+2. `nonce_bus` is valid in that same cycle.
- Throughput is one nonce per cycle when all slots are busy. `nonce_bus_wr` may stay high on consecutive cycles.
- `pending` is registered from `slot_v` and updates the cycle after capture or drain.
- `fifo_full` is sampled in the grant cycle. A full asserted in cycle N blocks the write that would appear in N+1.
- `drop_cnt` updates on the edge where the drop occurs and saturates at 16'hFFFF.

## Configuration
- `NONCE_ARB_DROP_CNT_EN` defined: the `drop_cnt` port and its counter are present.
- Undefined: the port is absent, and dropped nonces are discarded silently. Capture and grant behaviour are identical in both builds.

## Structure
- Shared package `miner_pkg` holds:
  - `NONCE_W` as a localparam default.
  - `nonce_t`, a typedef of `logic [NONCE_W-1:0]`.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are `req[NCORE]` and `ptr`; outputs are a one-hot grant and a grant index. It is reused later for job-dispatch arbitration.

## Test plan
- **Single result:** `NCORE`=2, `found[0]` with 64'h1122334455667788 in cycle 10 → `nonce_bus_wr`=1 in cycle 12 with `nonce_bus`=64'h1122334455667788; `pending` goes 1 then 0.
- **Simultaneous found:** `found`=2'b11 with `ptr`=0, nonces A and B → writes A then B on consecutive cycles; `ptr` returns to 0.
- **Back-pressure:** `fifo_full` high for 5 cycles while core 1 holds C → no `nonce_bus_wr` during those 5 cycles; C is written one cycle after `fifo_full` falls.
- **Overflow:** core 0 slot holds D under `fifo_full`, and a second `found[0]` arrives with E → D is later written, E never is; `drop_cnt`=1 with the macro defined.
- **Flush:** slots hold F and G, then `flush` is pulsed together with `found[1]` → no writes, `pending`=0.
- **Reset mid-drain:** `rst` is driven low asynchronously while `nonce_bus_wr`=1 → all outputs are 0 immediately; no write after `rst` is released.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared miner definitions: default nonce width, nonce type and a pointer-width helper.
package miner_pkg;

  localparam int unsigned NONCE_W = 64;

  typedef logic [NONCE_W-1:0] nonce_t;

  // Round-robin pointers keep at least one bit so single-core builds stay legal.
  function automatic int unsigned ptr_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NCORE.
module rr_pick #(
  parameter int unsigned NCORE = 2,
  parameter int unsigned PW    = miner_pkg::ptr_w(NCORE)
) (
  input  logic [NCORE-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NCORE-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NCORE); k++) begin
      idx = (int'(ptr) + k) % int'(NCORE);
      if (!gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/nonce_arbiter.sv
// Drains per-core one-deep nonce slots round-robin into the nonce FIFO write port.
// Optional saturating drop counter enabled by defining NONCE_ARB_DROP_CNT_EN.
module nonce_arbiter #(
  parameter int unsigned NCORE   = 2,
  parameter int unsigned NONCE_W = miner_pkg::NONCE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORE-1:0]         found,
  input  logic [NCORE*NONCE_W-1:0] found_nonce,
  input  logic                     flush,
  input  logic                     fifo_full,
  output logic [NONCE_W-1:0]       nonce_bus,
  output logic                     nonce_bus_wr,
`ifdef NONCE_ARB_DROP_CNT_EN
  output logic                     pending,
  output logic [15:0]              drop_cnt
`else
  output logic                     pending
`endif
);

  import miner_pkg::*;

  localparam int unsigned PW = ptr_w(NCORE);

  logic [NCORE-1:0]   slot_v, slot_v_d, gnt, take, drop;
  logic [NONCE_W-1:0] slot_d [NCORE];
  logic [PW-1:0]      ptr, ptr_d, gnt_idx;
  logic               gnt_any, grant;

  rr_pick #(
    .NCORE (NCORE),
    .PW    (PW)
  ) u_pick (
    .req     (slot_v),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign grant = gnt_any & ~fifo_full & ~flush;

  always_comb begin
    take     = '0;
    drop     = '0;
    slot_v_d = grant ? (slot_v & ~gnt) : slot_v;
    // A slot being drained this edge can accept a fresh nonce on the same edge.
    for (int i = 0; i < int'(NCORE); i++) begin
      if (found[i]) begin
        if (!slot_v[i] || (grant && gnt[i])) take[i] = 1'b1;
        else                                 drop[i] = 1'b1;
      end
    end
    slot_v_d = slot_v_d | take;
    if (flush) begin
      slot_v_d = '0;
      take     = '0;
      drop     = '0;
    end
    ptr_d = ptr;
    if (grant) ptr_d = PW'((int'(gnt_idx) + 1) % int'(NCORE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v       <= '0;
      ptr          <= '0;
      nonce_bus    <= '0;
      nonce_bus_wr <= 1'b0;
      pending      <= 1'b0;
    end else begin
      slot_v       <= slot_v_d;
      ptr          <= ptr_d;
      nonce_bus_wr <= grant;
      pending      <= |slot_v_d;
      if (grant) nonce_bus <= slot_d[gnt_idx];
    end
  end

  // Slot data is qualified by slot_v, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NCORE); i++) begin
      if (take[i]) slot_d[i] <= found_nonce[i*NONCE_W +: NONCE_W];
    end
  end

`ifdef NONCE_ARB_DROP_CNT_EN
  logic [4:0]  n_drop;
  logic [16:0] cnt_sum;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < int'(NCORE); i++) n_drop = n_drop + 5'(drop[i]);
    cnt_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else      drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_nonce_arbiter.sv
// Scoreboard bench for nonce_arbiter (NCORE=2): expected writes queued, monitor checks each write.
module tb_nonce_arbiter;

  localparam int NCORE   = 2;
  localparam int NONCE_W = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NCORE-1:0]         found = '0;
  logic [NCORE*NONCE_W-1:0] found_nonce = '0;
  logic                     flush = 1'b0;
  logic                     fifo_full = 1'b0;
  logic [NONCE_W-1:0]       nonce_bus;
  logic                     nonce_bus_wr;
  logic                     pending;
`ifdef NONCE_ARB_DROP_CNT_EN
  logic [15:0]              drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [NONCE_W-1:0] exp_q [$];

  nonce_arbiter #(
    .NCORE   (NCORE),
    .NONCE_W (NONCE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .found        (found),
    .found_nonce  (found_nonce),
    .flush        (flush),
    .fifo_full    (fifo_full),
    .nonce_bus    (nonce_bus),
    .nonce_bus_wr (nonce_bus_wr),
`ifdef NONCE_ARB_DROP_CNT_EN
    .pending      (pending),
    .drop_cnt     (drop_cnt)
`else
    .pending      (pending)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && nonce_bus_wr === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got %h expected no write", nonce_bus);
      end else begin
        logic [NONCE_W-1:0] e;
        e = exp_q.pop_front();
        if (nonce_bus !== e) begin
          bad++;
          $display("FAIL write_data: got %h expected %h", nonce_bus, e);
        end
      end
    end
  end

  localparam logic [63:0] NX = 64'h1122334455667788;
  localparam logic [63:0] NC = 64'hCCCC0000CCCC0001;
  localparam logic [63:0] ND = 64'hDDDD0000DDDD0002;
  localparam logic [63:0] NE = 64'hEEEE0000EEEE0003;
  localparam logic [63:0] NF = 64'hF0F0F0F0F0F0F0F0;
  localparam logic [63:0] NG = 64'h0606060606060606;
  localparam logic [63:0] NH = 64'h4848484848484848;
  localparam logic [63:0] R0 = 64'hAAAA5555AAAA5555;
  localparam logic [63:0] R1 = 64'h5555AAAA5555AAAA;

  logic [63:0] pair_a [2];
  logic [63:0] pair_b [2];

  initial begin
    pair_a[0] = 64'h00000000000000A1; pair_b[0] = 64'h00000000000000B1;
    pair_a[1] = 64'h00000000000000A2; pair_b[1] = 64'h00000000000000B2;

    // Reset state
    #3;
    check("rst_bus", 64'(nonce_bus), 64'h0);
    check("rst_wr", 64'(nonce_bus_wr), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
`ifdef NONCE_ARB_DROP_CNT_EN
    check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) cyc();

    // Single result: write two cycles after found
    found = 2'b01; found_nonce = {64'h0, NX};
    exp_q.push_back(NX);
    @(negedge clk); check("single_n_wr", 64'(nonce_bus_wr), 64'h0);
    cyc(); found = '0;
    @(negedge clk);
    check("single_n1_wr", 64'(nonce_bus_wr), 64'h0);
    check("single_n1_pending", 64'(pending), 64'h1);
    cyc();
    @(negedge clk);
    check("single_n2_wr", 64'(nonce_bus_wr), 64'h1);
    check("single_n2_bus", nonce_bus, NX);
    check("single_n2_pending", 64'(pending), 64'h0);
    cyc();

    // Back-pressure: core 1 holds C for 5 full cycles (ptr is 1 here)
    fifo_full = 1'b1; found = 2'b10; found_nonce = {NC, 64'h0};
    exp_q.push_back(NC);
    @(negedge clk); check("bp_wr_0", 64'(nonce_bus_wr), 64'h0);
    cyc(); found = '0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk); check("bp_wr_hold", 64'(nonce_bus_wr), 64'h0);
      cyc();
    end
    fifo_full = 1'b0;
    @(negedge clk); check("bp_wr_release", 64'(nonce_bus_wr), 64'h0);
    cyc();
    @(negedge clk);
    check("bp_wr_c", 64'(nonce_bus_wr), 64'h1);
    check("bp_bus_c", nonce_bus, NC);
    cyc();

    // Simultaneous found twice: ptr back at 0 means core 0 wins both times
    for (int p = 0; p < 2; p++) begin
      found = 2'b11; found_nonce = {pair_b[p], pair_a[p]};
      exp_q.push_back(pair_a[p]);
      exp_q.push_back(pair_b[p]);
      cyc(); found = '0;
      cyc();
      @(negedge clk);
      check("simul_first", nonce_bus, pair_a[p]);
      cyc();
      @(negedge clk);
      check("simul_second_wr", 64'(nonce_bus_wr), 64'h1);
      check("simul_second", nonce_bus, pair_b[p]);
      cyc();
    end

    // Overflow: E dropped while D held under back-pressure
    fifo_full = 1'b1; found = 2'b01; found_nonce = {64'h0, ND};
    exp_q.push_back(ND);
    cyc(); found_nonce = {64'h0, NE};
    cyc(); found = '0; fifo_full = 1'b0;
    cyc();
    @(negedge clk);
    check("ovf_wr", 64'(nonce_bus_wr), 64'h1);
    check("ovf_bus", nonce_bus, ND);
    repeat (3) cyc();
    @(negedge clk); check("ovf_pending", 64'(pending), 64'h0);
`ifdef NONCE_ARB_DROP_CNT_EN
    check("ovf_drop_cnt", 64'(drop_cnt), 64'h1);
`endif

    // Flush: F and G held, flush together with found[1]
    cyc();
    fifo_full = 1'b1; found = 2'b11; found_nonce = {NG, NF};
    cyc(); found = '0;
    @(negedge clk); check("flush_pre_pending", 64'(pending), 64'h1);
    cyc(); flush = 1'b1; found = 2'b10; found_nonce = {NH, 64'h0};
    cyc(); flush = 1'b0; found = '0; fifo_full = 1'b0;
    @(negedge clk); check("flush_pending", 64'(pending), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk); check("flush_no_wr", 64'(nonce_bus_wr), 64'h0);
    end
    cyc();

    // Reset mid-drain (ptr is 1, so core 1 drains first)
    found = 2'b11; found_nonce = {R1, R0};
    cyc(); found = '0;
    cyc(); #1;
    check("rmd_wr_before", 64'(nonce_bus_wr), 64'h1);
    check("rmd_bus_before", nonce_bus, R1);
    rst = 1'b0;
    #1;
    check("rmd_wr", 64'(nonce_bus_wr), 64'h0);
    check("rmd_bus", 64'(nonce_bus), 64'h0);
    check("rmd_pending", 64'(pending), 64'h0);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      check("rmd_no_wr", 64'(nonce_bus_wr), 64'h0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
